// File: rtl/brseq_pkg.sv
// Shared types for the conditional-branch sequencer: state enum, C2 encodings
// and the Moore strobe decode used by branch_sequencer.
package brseq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T3   = 3'd1,
    T4   = 3'd2,
    T5   = 3'd3,
    T6   = 3'd4,
    DONE = 3'd5
  } brseq_state_e;

  localparam logic [3:0] BR_ZR = 4'b0000;
  localparam logic [3:0] BR_NZ = 4'b0001;
  localparam logic [3:0] BR_PL = 4'b0010;
  localparam logic [3:0] BR_MI = 4'b0011;

  typedef struct packed {
    logic gra;
    logic r_out;
    logic con_in;
    logic pc_out;
    logic y_in;
    logic c_out;
    logic alu_add;
    logic z_in;
    logic zlow_out;
    logic pc_in;
    logic busy;
    logic done;
    logic taken;
    logic bad_cond;
  } brseq_strb_t;

  function automatic logic cond_legal(input logic [3:0] c2);
    return (c2 <= BR_MI);
  endfunction

  // At most one of r_out/pc_out/c_out/zlow_out is set in any state.
  function automatic brseq_strb_t decode_strobes(input brseq_state_e st,
                                                 input logic met,
                                                 input logic [3:0] c2);
    brseq_strb_t s;
    s = '0;
    case (st)
      IDLE: s.busy = 1'b0;
      T3: begin
        s.gra    = 1'b1;
        s.r_out  = 1'b1;
        s.con_in = 1'b1;
        s.busy   = 1'b1;
      end
      T4: begin
        s.pc_out = 1'b1;
        s.y_in   = 1'b1;
        s.busy   = 1'b1;
      end
      T5: begin
        s.c_out   = 1'b1;
        s.alu_add = 1'b1;
        s.z_in    = 1'b1;
        s.busy    = 1'b1;
      end
      T6: begin
        s.zlow_out = 1'b1;
        s.pc_in    = met;
        s.busy     = 1'b1;
      end
      DONE: begin
        s.done     = 1'b1;
        s.taken    = met;
        s.bad_cond = ~cond_legal(c2);
        s.busy     = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/brseq_stats.sv
// Saturating taken / not-taken branch counters with synchronous clear.
module brseq_stats
  import brseq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stats_clr,
  input  logic             inc_taken,
  input  logic             inc_not_taken,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] not_taken_cnt_q, not_taken_cnt_d;

  // Next-count: clear wins over increment, counters stick at all-ones.
  always_comb begin
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;
    if (stats_clr) begin
      taken_cnt_d     = '0;
      not_taken_cnt_d = '0;
    end else begin
      if (inc_taken && (taken_cnt_q != CNT_MAX)) begin
        taken_cnt_d = taken_cnt_q + CNT_ONE;
      end else begin
        taken_cnt_d = taken_cnt_q;
      end
      if (inc_not_taken && (not_taken_cnt_q != CNT_MAX)) begin
        not_taken_cnt_d = not_taken_cnt_q + CNT_ONE;
      end else begin
        not_taken_cnt_d = not_taken_cnt_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else begin
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;

endmodule

// File: rtl/branch_sequencer.sv
// Steps one brzr/brnz/brpl/brmi through T3..T6 and loads PC when CON holds.
// Optional statistics counters are built when BRSEQ_STATS_EN is defined.
module branch_sequencer
  import brseq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       c2,
  input  logic             con_met,
  output logic             gra,
  output logic             r_out,
  output logic             con_in,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             zlow_out,
  output logic             pc_in,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic             bad_cond
`ifdef BRSEQ_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
`endif
);

  brseq_state_e state_q, state_d;
  logic [3:0]   c2_q, c2_d;
  logic         met_q, met_d;
  brseq_strb_t  strb_q, strb_d;

  // Next-state and capture logic; strobes are decoded from the next state so
  // the outputs come straight off flops yet line up with the state register.
  always_comb begin
    state_d = state_q;
    c2_d    = c2_q;
    met_d   = met_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = T3;
          c2_d    = c2;
          met_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      T3: state_d = T4;
      T4: begin
        // CON was strobed a full cycle ago, so con_met has settled by now.
        state_d = T5;
        met_d   = cond_legal(c2_q) ? con_met : 1'b0;
      end
      T5:      state_d = T6;
      T6:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    strb_d = decode_strobes(state_d, met_d, c2_d);
  end

  // State, captured condition and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      c2_q    <= 4'b0000;
      met_q   <= 1'b0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      c2_q    <= c2_d;
      met_q   <= met_d;
      strb_q  <= strb_d;
    end
  end

  assign gra      = strb_q.gra;
  assign r_out    = strb_q.r_out;
  assign con_in   = strb_q.con_in;
  assign pc_out   = strb_q.pc_out;
  assign y_in     = strb_q.y_in;
  assign c_out    = strb_q.c_out;
  assign alu_add  = strb_q.alu_add;
  assign z_in     = strb_q.z_in;
  assign zlow_out = strb_q.zlow_out;
  assign pc_in    = strb_q.pc_in;
  assign busy     = strb_q.busy;
  assign done     = strb_q.done;
  assign taken    = strb_q.taken;
  assign bad_cond = strb_q.bad_cond;

`ifdef BRSEQ_STATS_EN
  brseq_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clock         (clock),
    .reset_n       (reset_n),
    .stats_clr     (stats_clr),
    .inc_taken     (strb_q.done & strb_q.taken),
    .inc_not_taken (strb_q.done & ~strb_q.taken),
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
  );
`else
  logic [CNT_W-1:0] unused_cnt_s;
  assign unused_cnt_s = '0;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed cases plus randomized
// branches against a cycle-offset reference model of the branch micro-steps.
module tb_branch_sequencer;

  localparam int TB_CNT_W = 2;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clock = 1'b0;
  logic reset_n, start, con_met;
  logic [3:0] c2;
  logic gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out;
  logic pc_in, busy, done, taken, bad_cond;
  logic stats_clr;
  logic [TB_CNT_W-1:0] taken_cnt, not_taken_cnt;

  int checks = 0;
  int errors = 0;
  int mdl_tk = 0;
  int mdl_nt = 0;

  branch_sequencer #(.CNT_W(TB_CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .c2(c2), .con_met(con_met),
    .gra(gra), .r_out(r_out), .con_in(con_in), .pc_out(pc_out), .y_in(y_in),
    .c_out(c_out), .alu_add(alu_add), .z_in(z_in), .zlow_out(zlow_out),
    .pc_in(pc_in), .busy(busy), .done(done), .taken(taken), .bad_cond(bad_cond)
`ifdef BRSEQ_STATS_EN
    , .stats_clr(stats_clr), .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
`endif
  );

`ifndef BRSEQ_STATS_EN
  assign taken_cnt     = '0;
  assign not_taken_cnt = '0;
`endif

  always #5 clock = ~clock;

  function automatic logic [13:0] obs_vec();
    return {gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
            zlow_out, pc_in, busy, done, taken, bad_cond};
  endfunction

  // CON flip-flop behaviour: condition of Ra selected by C2.
  function automatic logic con_model(input logic [3:0] cc, input logic [31:0] ra);
    case (cc)
      4'd0:    return (ra == 32'd0);
      4'd1:    return (ra != 32'd0);
      4'd2:    return (ra[31] == 1'b0);
      4'd3:    return (ra[31] == 1'b1);
      default: return 1'b0;
    endcase
  endfunction

  // Expected strobes at cycle offset off after the accept edge.
  function automatic logic [13:0] exp_vec(input int off, input logic tk, input logic bad);
    logic g, ro, ci, po, yi, co, aa, zi, zo, pi, bz, dn, to, bd;
    {g, ro, ci, po, yi, co, aa, zi, zo, pi, bz, dn, to, bd} = 14'd0;
    bz = (off >= 1 && off <= 5);
    case (off)
      1: {g, ro, ci} = 3'b111;
      2: {po, yi} = 2'b11;
      3: {co, aa, zi} = 3'b111;
      4: begin zo = 1'b1; pi = tk; end
      5: begin dn = 1'b1; to = tk; bd = bad; end
      default: ;
    endcase
    return {g, ro, ci, po, yi, co, aa, zi, zo, pi, bz, dn, to, bd};
  endfunction

  task automatic check_vec(input string tag, input logic [13:0] exp);
    logic [13:0] o;
    o = obs_vec();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, o, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
`ifdef BRSEQ_STATS_EN
    checks++;
    assert (taken_cnt === TB_CNT_W'(mdl_tk) && not_taken_cnt === TB_CNT_W'(mdl_nt)) else begin
      errors++;
      $error("FAIL %s: observed tk=%0d nt=%0d expected tk=%0d nt=%0d",
             tag, taken_cnt, not_taken_cnt, mdl_tk, mdl_nt);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One branch from accept to the IDLE cycle after DONE. pre: start already high.
  task automatic run_branch(input string tag, input logic [3:0] cc, input logic [31:0] ra,
                            input bit force_met, input bit pre, input bit hold, input bit clr);
    logic met, tk, bad;
    met = force_met ? 1'b1 : con_model(cc, ra);
    bad = (cc > 4'd3);
    tk  = met && !bad;
    if (!pre) @(negedge clock);
    start = 1'b1; c2 = cc; con_met = met;
    @(posedge clock);
    for (int off = 1; off <= 6; off++) begin
      @(negedge clock);
      check_vec($sformatf("%s_off%0d", tag, off), exp_vec(off, tk, bad));
      if (off == 6) begin
        if (clr) begin mdl_tk = 0; mdl_nt = 0; end
        else if (tk) mdl_tk = (mdl_tk < CNT_MAX) ? mdl_tk + 1 : CNT_MAX;
        else mdl_nt = (mdl_nt < CNT_MAX) ? mdl_nt + 1 : CNT_MAX;
        check_cnt({tag, "_cnt"});
      end
      start     = hold && off >= 2;
      stats_clr = clr && off == 5;
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; c2 = 4'd0; con_met = 1'b0; stats_clr = 1'b0;
    #1;
    check_vec("reset_outputs", 14'd0);
    check_cnt("reset_cnt");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_vec("idle_after_reset", 14'd0);

    run_branch("brzr_taken", 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_branch("brmi_not_taken", 4'd3, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0);
    run_branch("illegal_c2", 4'b0111, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_branch("brnz_taken", 4'd1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    run_branch("brpl_not_taken", 4'd2, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start raised in T4 and held: one sequence, next accept at end of k+6.
    run_branch("busy_start", 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_branch("after_busy", 4'd1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset dropped in T5.
    @(negedge clock);
    start = 1'b1; c2 = 4'd0; con_met = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check_vec("async_reset_mid_op", 14'd0);
    mdl_tk = 0; mdl_nt = 0;
    check_cnt("reset_mid_op_cnt");
    @(negedge clock); reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      check_vec($sformatf("post_reset_idle%0d", i), 14'd0);
    end

    for (int n = 0; n < 24; n++) begin
      logic [3:0]  rc;
      logic [31:0] rr;
      rc = 4'($urandom_range(0, 5));
      rr = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      run_branch($sformatf("rand%0d", n), rc, rr, 1'($urandom_range(0, 1)),
                 1'b0, 1'b0, 1'b0);
    end

`ifdef BRSEQ_STATS_EN
    run_branch("stats_clr0", 4'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++)
      run_branch($sformatf("stats_tk%0d", n), 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    assert (taken_cnt === 2'd3) else begin
      errors++;
      $error("FAIL stats_saturate: observed %0d expected 3", taken_cnt);
    end
    run_branch("stats_clr_done", 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    assert (taken_cnt === 2'd0) else begin
      errors++;
      $error("FAIL stats_clr_priority: observed %0d expected 0", taken_cnt);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
